// File: rtl/dino_game_pkg.sv
// Shared types and default constants for the dino runner game sequencer.
package dino_game_pkg;

  // Width of every coordinate bus driven to the VGA controller.
  localparam int COORD_W = 32;

  // Default playfield geometry and motion constants.
  localparam int DINO_X_DEFAULT       = 100;
  localparam int GROUND_Y_DEFAULT     = 400;
  localparam int JUMP_HEIGHT_DEFAULT  = 96;
  localparam int JUMP_STEP_DEFAULT    = 8;
  localparam int OBST_START_X_DEFAULT = 640;
  localparam int OBST_SPEED_DEFAULT   = 4;

  // Game FSM states; the encoding is visible on the state output port.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RUN  = 3'd1,
    ST_RISE = 3'd2,
    ST_FALL = 3'd3,
    ST_OVER = 3'd4
  } game_state_e;

endpackage

// File: rtl/button_edge_sync.sv
// Two-flop synchroniser followed by a rising-edge detector. A held input
// yields exactly one single-cycle pulse.
module button_edge_sync (
  input  logic clk,
  input  logic reset,
  input  logic level,
  output logic rise
);

  logic meta_reg;
  logic sync_reg;
  logic sync_q_reg;

  // Resynchronise the raw input and keep one cycle of history for edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_reg   <= 1'b0;
      sync_reg   <= 1'b0;
      sync_q_reg <= 1'b0;
    end else begin
      meta_reg   <= level;
      sync_reg   <= meta_reg;
      sync_q_reg <= sync_reg;
    end
  end

  assign rise = sync_reg & ~sync_q_reg;

endmodule

// File: rtl/dino_game_sequencer.sv
// Dino runner game sequencer: advances dino jump and obstacle scroll once per
// displayed frame, tracks score and detects game over.
module dino_game_sequencer
  import dino_game_pkg::*;
#(
  parameter int DINO_X       = DINO_X_DEFAULT,
  parameter int GROUND_Y     = GROUND_Y_DEFAULT,
  parameter int JUMP_HEIGHT  = JUMP_HEIGHT_DEFAULT,
  parameter int JUMP_STEP    = JUMP_STEP_DEFAULT,
  parameter int OBST_START_X = OBST_START_X_DEFAULT,
  parameter int OBST_SPEED   = OBST_SPEED_DEFAULT,
  parameter int SCORE_W      = 20
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               button_press,
  input  logic               screen_ready,
  input  logic               collision_detected,
  output logic [COORD_W-1:0] x_coor,
  output logic [COORD_W-1:0] y_coor,
  output logic [COORD_W-1:0] x_coor_obstacle,
  output logic [COORD_W-1:0] y_coor_obstacle,
  output logic [SCORE_W-1:0] score,
  output logic               game_over,
  output logic [2:0]         state
);

  localparam logic [COORD_W-1:0] GROUND_C  = COORD_W'(GROUND_Y);
  localparam logic [COORD_W-1:0] HEIGHT_C  = COORD_W'(JUMP_HEIGHT);
  localparam logic [COORD_W-1:0] STEP_C    = COORD_W'(JUMP_STEP);
  localparam logic [COORD_W-1:0] START_C   = COORD_W'(OBST_START_X);
  localparam logic [COORD_W-1:0] SPEED_C   = COORD_W'(OBST_SPEED);
  localparam logic [SCORE_W-1:0] SCORE_MAX = {SCORE_W{1'b1}};

  logic btn_edge;
  logic tick;

  game_state_e        state_reg, state_next;
  logic [COORD_W-1:0] jump_ofs_reg, jump_ofs_next;
  logic [COORD_W-1:0] y_reg, y_next;
  logic [COORD_W-1:0] obst_x_reg, obst_x_next;
  logic [SCORE_W-1:0] score_reg, score_next;
  logic               game_over_reg, game_over_next;
  logic               screen_ready_q_reg;

  button_edge_sync u_button_sync (
    .clk   (clk),
    .reset (reset),
    .level (button_press),
    .rise  (btn_edge)
  );

  // One tick per rising edge of the frame-ready level.
  assign tick = screen_ready & ~screen_ready_q_reg;

  // State and datapath registers; y is kept registered alongside jump_ofs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg          <= ST_IDLE;
      jump_ofs_reg       <= '0;
      y_reg              <= GROUND_C;
      obst_x_reg         <= START_C;
      score_reg          <= '0;
      game_over_reg      <= 1'b0;
      screen_ready_q_reg <= 1'b0;
    end else begin
      state_reg          <= state_next;
      jump_ofs_reg       <= jump_ofs_next;
      y_reg              <= y_next;
      obst_x_reg         <= obst_x_next;
      score_reg          <= score_next;
      game_over_reg      <= game_over_next;
      screen_ready_q_reg <= screen_ready;
    end
  end

  // Next-state and next-datapath logic; collision pre-empts tick and button.
  always_comb begin
    state_next     = state_reg;
    jump_ofs_next  = jump_ofs_reg;
    obst_x_next    = obst_x_reg;
    score_next     = score_reg;
    game_over_next = game_over_reg;

    case (state_reg)
      ST_IDLE: begin
        if (btn_edge) state_next = ST_RUN;
      end

      ST_RUN, ST_RISE, ST_FALL: begin
        if (collision_detected) begin
          state_next     = ST_OVER;
          game_over_next = 1'b1;
        end else begin
          if (tick) begin
            if (obst_x_reg < SPEED_C) begin
              obst_x_next = START_C;
              if (score_reg != SCORE_MAX) score_next = score_reg + SCORE_W'(1);
            end else begin
              obst_x_next = obst_x_reg - SPEED_C;
            end
          end

          if (state_reg == ST_RUN) begin
            if (btn_edge) state_next = ST_RISE;
          end else if (state_reg == ST_RISE) begin
            if (tick) begin
              jump_ofs_next = jump_ofs_reg + STEP_C;
              if (jump_ofs_next == HEIGHT_C) state_next = ST_FALL;
            end
          end else begin
            if (tick) begin
              jump_ofs_next = jump_ofs_reg - STEP_C;
              if (jump_ofs_next == '0) state_next = ST_RUN;
            end
          end
        end
      end

      ST_OVER: begin
        if (btn_edge) begin
          state_next     = ST_IDLE;
          jump_ofs_next  = '0;
          obst_x_next    = START_C;
          score_next     = '0;
          game_over_next = 1'b0;
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase

    y_next = GROUND_C - jump_ofs_next;
  end

  assign x_coor          = COORD_W'(DINO_X);
  assign y_coor          = y_reg;
  assign x_coor_obstacle = obst_x_reg;
  assign y_coor_obstacle = GROUND_C;
  assign score           = score_reg;
  assign game_over       = game_over_reg;
  assign state           = state_reg;

endmodule

// File: tb/tb_dino_game_sequencer.sv
// Directed testbench for dino_game_sequencer (score counter narrowed to 2 bits
// so saturation is reachable quickly).
module tb_dino_game_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        button_press = 1'b0;
  logic        screen_ready = 1'b0;
  logic        collision_detected = 1'b0;
  logic [31:0] x_coor;
  logic [31:0] y_coor;
  logic [31:0] x_coor_obstacle;
  logic [31:0] y_coor_obstacle;
  logic [1:0]  score;
  logic        game_over;
  logic [2:0]  state;

  int checks = 0;
  int failures = 0;

  localparam logic [31:0] S_IDLE = 0;
  localparam logic [31:0] S_RUN  = 1;
  localparam logic [31:0] S_RISE = 2;
  localparam logic [31:0] S_FALL = 3;
  localparam logic [31:0] S_OVER = 4;

  dino_game_sequencer #(.SCORE_W(2)) dut (
    .clk                (clk),
    .reset              (reset),
    .button_press       (button_press),
    .screen_ready       (screen_ready),
    .collision_detected (collision_detected),
    .x_coor             (x_coor),
    .y_coor             (y_coor),
    .x_coor_obstacle    (x_coor_obstacle),
    .y_coor_obstacle    (y_coor_obstacle),
    .score              (score),
    .game_over          (game_over),
    .state              (state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One frame: screen_ready high for one cycle; returns on the negedge after the update.
  task automatic do_tick();
    @(negedge clk) screen_ready = 1'b1;
    @(negedge clk) screen_ready = 1'b0;
  endtask

  task automatic press(input int hold);
    @(negedge clk) button_press = 1'b1;
    repeat (hold) @(negedge clk);
    button_press = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic check_all_reset(input string tag);
    check({tag, "_state"}, 32'(state), S_IDLE);
    check({tag, "_x"}, x_coor, 32'd100);
    check({tag, "_y"}, y_coor, 32'd400);
    check({tag, "_xobs"}, x_coor_obstacle, 32'd640);
    check({tag, "_yobs"}, y_coor_obstacle, 32'd400);
    check({tag, "_score"}, 32'(score), 32'd0);
    check({tag, "_go"}, 32'(game_over), 32'd0);
  endtask

  initial begin
    // Reset values
    repeat (3) @(negedge clk);
    check_all_reset("reset");
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Tick in IDLE leaves positions frozen
    do_tick();
    check("idle_tick_xobs", x_coor_obstacle, 32'd640);
    check("idle_tick_state", 32'(state), S_IDLE);

    // Start: long press, exactly one transition to RUN
    press(10);
    check("start_state", 32'(state), S_RUN);
    check("start_y", y_coor, 32'd400);
    check("start_xobs", x_coor_obstacle, 32'd640);
    check("start_score", 32'(score), 32'd0);

    // Full jump
    press(2);
    check("jump_begin_state", 32'(state), S_RISE);
    check("jump_begin_y", y_coor, 32'd400);
    for (int k = 1; k <= 24; k++) begin
      do_tick();
      if (k <= 12) check($sformatf("jump_y_t%0d", k), y_coor, 32'(400 - 8 * k));
      else         check($sformatf("jump_y_t%0d", k), y_coor, 32'(304 + 8 * (k - 12)));
      if (k == 6 || k == 18) begin
        press(2);
        check($sformatf("jump_repress_y_t%0d", k), y_coor, k == 6 ? 32'd352 : 32'd352);
      end
      if (k == 11) check("jump_state_t11", 32'(state), S_RISE);
      if (k == 12) check("jump_state_t12", 32'(state), S_FALL);
      if (k == 23) check("jump_state_t23", 32'(state), S_FALL);
    end
    check("jump_end_state", 32'(state), S_RUN);
    check("jump_end_xobs", x_coor_obstacle, 32'd544);

    // Scroll to zero, then respawn
    repeat (136) do_tick();
    check("scroll_zero_xobs", x_coor_obstacle, 32'd0);
    check("scroll_zero_score", 32'(score), 32'd0);
    do_tick();
    check("respawn_xobs", x_coor_obstacle, 32'd640);
    check("respawn_score", 32'(score), 32'd1);
    for (int r = 0; r < 2; r++) begin
      repeat (161) do_tick();
      check($sformatf("respawn%0d_score", r + 2), 32'(score), 32'(r + 2));
    end
    repeat (161) do_tick();
    check("saturate_score", 32'(score), 32'd3);
    check("saturate_xobs", x_coor_obstacle, 32'd640);

    // Collision priority in RISE
    press(2);
    check("coll_pre_state", 32'(state), S_RISE);
    repeat (2) do_tick();
    check("coll_pre_y", y_coor, 32'd384);
    check("coll_pre_xobs", x_coor_obstacle, 32'd632);
    @(negedge clk) button_press = 1'b1;
    @(negedge clk);
    @(negedge clk) begin
      screen_ready = 1'b1;
      collision_detected = 1'b1;
    end
    @(negedge clk);
    check("coll_state", 32'(state), S_OVER);
    check("coll_go", 32'(game_over), 32'd1);
    check("coll_y", y_coor, 32'd384);
    check("coll_xobs", x_coor_obstacle, 32'd632);
    screen_ready = 1'b0;
    button_press = 1'b0;
    repeat (4) @(negedge clk);
    for (int k = 0; k < 10; k++) begin
      collision_detected = k[0];
      do_tick();
    end
    collision_detected = 1'b0;
    check("over_frozen_state", 32'(state), S_OVER);
    check("over_frozen_y", y_coor, 32'd384);
    check("over_frozen_xobs", x_coor_obstacle, 32'd632);
    check("over_frozen_score", 32'(score), 32'd3);

    // Restart
    press(2);
    check_all_reset("restart");
    press(2);
    check("restart_run", 32'(state), S_RUN);

    // Asynchronous reset mid-jump
    press(2);
    check("mid_state", 32'(state), S_RISE);
    repeat (6) do_tick();
    check("mid_y", y_coor, 32'd352);
    check("mid_xobs", x_coor_obstacle, 32'd616);
    @(negedge clk);
    #2 reset = 1'b1;
    #1 check_all_reset("async");
    @(negedge clk) reset = 1'b0;
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
